// File: rtl/gelato_ibuffer.sv
// Per-warp instruction buffer between decode and issue.
// Each warp owns a small circular FIFO, and the scheduler pops into a registered issue stage.
module gelato_ibuffer #(
    parameter int WARP_NUM   = 8,
    parameter int DEPTH      = 2,
    parameter int ADDR_W     = 32,
    parameter int THREAD_NUM = 32,
    parameter int INST_W     = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [ADDR_W-1:0]           in_pc,
    input  logic [$clog2(WARP_NUM)-1:0] in_warp_num,
    input  logic [THREAD_NUM-1:0]       in_thread_mask,
    input  logic [INST_W-1:0]           in_inst,
    output logic [WARP_NUM-1:0]         warp_full,
    output logic [WARP_NUM-1:0]         warp_nonempty,
    input  logic                        issue_req,
    input  logic [$clog2(WARP_NUM)-1:0] issue_warp,
    input  logic                        flush_valid,
    input  logic [$clog2(WARP_NUM)-1:0] flush_warp,
    output logic                        out_valid,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [$clog2(WARP_NUM)-1:0] out_warp_num,
    output logic [THREAD_NUM-1:0]       out_thread_mask,
    output logic [INST_W-1:0]           out_inst,
    output logic                        overflow_err
);
    localparam int WW = $clog2(WARP_NUM);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Handshake: in_valid and issue_req carry no ready. Fetch must not send a warp
    // whose warp_full bit is set, and the scheduler should only pick a warp whose
    // warp_nonempty bit is set. A write to a full warp is dropped and flagged, and a pop
    // from an empty warp does nothing.

    logic [ADDR_W-1:0]     mem_pc   [WARP_NUM][DEPTH];
    logic [THREAD_NUM-1:0] mem_mask [WARP_NUM][DEPTH];
    logic [INST_W-1:0]     mem_inst [WARP_NUM][DEPTH];

    logic [PW-1:0] rd_ptr [WARP_NUM];
    logic [PW-1:0] wr_ptr [WARP_NUM];
    logic [CW-1:0] count  [WARP_NUM];

    logic in_flushed;
    logic in_full;
    logic pop_ok;
    logic pop_same;
    logic wr_ok;
    logic ovf_hit;
    logic [WARP_NUM-1:0] wr_sel;
    logic [WARP_NUM-1:0] pop_sel;
    logic [WARP_NUM-1:0] flush_sel;

    // Flush beats both write and pop on its own warp. A pop on a full warp frees the
    // slot that a same-cycle write then takes.
    always_comb begin
        in_flushed = flush_valid && (flush_warp == in_warp_num);
        in_full    = (count[in_warp_num] == FULL_CNT);
        pop_ok     = issue_req && (count[issue_warp] != '0)
                     && !(flush_valid && (flush_warp == issue_warp));
        pop_same   = pop_ok && (issue_warp == in_warp_num);
        wr_ok      = in_valid && !in_flushed && (!in_full || pop_same);
        ovf_hit    = in_valid && !in_flushed && in_full && !pop_same;
    end

    always_comb begin
        wr_sel        = '0;
        pop_sel       = '0;
        flush_sel     = '0;
        warp_full     = '0;
        warp_nonempty = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            wr_sel[w]        = wr_ok && (in_warp_num == WW'(w));
            pop_sel[w]       = pop_ok && (issue_warp == WW'(w));
            flush_sel[w]     = flush_valid && (flush_warp == WW'(w));
            warp_full[w]     = (count[w] == FULL_CNT);
            warp_nonempty[w] = (count[w] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WARP_NUM; w++) begin
                rd_ptr[w] <= '0;
                wr_ptr[w] <= '0;
                count[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < WARP_NUM; w++) begin
                if (flush_sel[w]) begin
                    rd_ptr[w] <= '0;
                    wr_ptr[w] <= '0;
                    count[w]  <= '0;
                end else begin
                    if (wr_sel[w])  wr_ptr[w] <= wr_ptr[w] + PW'(1);
                    if (pop_sel[w]) rd_ptr[w] <= rd_ptr[w] + PW'(1);
                    if (wr_sel[w] && !pop_sel[w])
                        count[w] <= count[w] + CW'(1);
                    else if (pop_sel[w] && !wr_sel[w])
                        count[w] <= count[w] - CW'(1);
                end
            end
        end
    end

    // Entry storage has no reset: its contents only matter behind a valid count.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_pc[in_warp_num][wr_ptr[in_warp_num]]   <= in_pc;
            mem_mask[in_warp_num][wr_ptr[in_warp_num]] <= in_thread_mask;
            mem_inst[in_warp_num][wr_ptr[in_warp_num]] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_warp_num    <= '0;
            out_thread_mask <= '0;
            out_inst        <= '0;
            overflow_err    <= 1'b0;
        end else begin
            out_valid <= pop_ok;
            if (pop_ok) begin
                out_pc          <= mem_pc[issue_warp][rd_ptr[issue_warp]];
                out_warp_num    <= issue_warp;
                out_thread_mask <= mem_mask[issue_warp][rd_ptr[issue_warp]];
                out_inst        <= mem_inst[issue_warp][rd_ptr[issue_warp]];
            end
            if (ovf_hit) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gelato_ibuffer.sv
// Directed bench for gelato_ibuffer: hand-computed vectors plus an expected queue
// for the interleaved multi-warp traffic.
module tb_gelato_ibuffer;
    localparam int WARP_NUM   = 8;
    localparam int DEPTH      = 2;
    localparam int ADDR_W     = 32;
    localparam int THREAD_NUM = 32;
    localparam int INST_W     = 64;
    localparam int WW         = 3;
    localparam int ENT_W      = ADDR_W + THREAD_NUM + INST_W;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic [ADDR_W-1:0]     in_pc;
    logic [WW-1:0]         in_warp_num;
    logic [THREAD_NUM-1:0] in_thread_mask;
    logic [INST_W-1:0]     in_inst;
    logic [WARP_NUM-1:0]   warp_full;
    logic [WARP_NUM-1:0]   warp_nonempty;
    logic                  issue_req;
    logic [WW-1:0]         issue_warp;
    logic                  flush_valid;
    logic [WW-1:0]         flush_warp;
    logic                  out_valid;
    logic [ADDR_W-1:0]     out_pc;
    logic [WW-1:0]         out_warp_num;
    logic [THREAD_NUM-1:0] out_thread_mask;
    logic [INST_W-1:0]     out_inst;
    logic                  overflow_err;

    gelato_ibuffer #(
        .WARP_NUM(WARP_NUM), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .THREAD_NUM(THREAD_NUM), .INST_W(INST_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_warp_num(in_warp_num),
        .in_thread_mask(in_thread_mask), .in_inst(in_inst),
        .warp_full(warp_full), .warp_nonempty(warp_nonempty),
        .issue_req(issue_req), .issue_warp(issue_warp),
        .flush_valid(flush_valid), .flush_warp(flush_warp),
        .out_valid(out_valid), .out_pc(out_pc), .out_warp_num(out_warp_num),
        .out_thread_mask(out_thread_mask), .out_inst(out_inst),
        .overflow_err(overflow_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [ENT_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [ENT_W-1:0] got,
                            input logic [ENT_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid       = 1'b0;
        in_pc          = '0;
        in_warp_num    = '0;
        in_thread_mask = '0;
        in_inst        = '0;
        issue_req      = 1'b0;
        issue_warp     = '0;
        flush_valid    = 1'b0;
        flush_warp     = '0;
    endtask

    task automatic drive(input logic iv, input logic [WW-1:0] iw, input logic [ADDR_W-1:0] pc,
                         input logic [THREAD_NUM-1:0] mask, input logic [INST_W-1:0] inst,
                         input logic ir, input logic [WW-1:0] isw,
                         input logic fv, input logic [WW-1:0] fw);
        in_valid       = iv;
        in_warp_num    = iw;
        in_pc          = pc;
        in_thread_mask = mask;
        in_inst        = inst;
        issue_req      = ir;
        issue_warp     = isw;
        flush_valid    = fv;
        flush_warp     = fw;
        tick();
        clear_inputs();
    endtask

    task automatic write(input logic [WW-1:0] w, input logic [ADDR_W-1:0] pc,
                         input logic [THREAD_NUM-1:0] mask, input logic [INST_W-1:0] inst);
        drive(1'b1, w, pc, mask, inst, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic pop(input logic [WW-1:0] w);
        drive(1'b0, '0, '0, '0, '0, 1'b1, w, 1'b0, '0);
    endtask

    task automatic check_out(input string tag, input logic [WW-1:0] w, input logic [ADDR_W-1:0] pc,
                             input logic [THREAD_NUM-1:0] mask, input logic [INST_W-1:0] inst);
        check_eq({tag, "_valid"}, ENT_W'(out_valid), ENT_W'(1'b1));
        check_eq({tag, "_warp"}, ENT_W'(out_warp_num), ENT_W'(w));
        check_eq({tag, "_data"}, {out_pc, out_thread_mask, out_inst}, {pc, mask, inst});
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0]     pc;
        logic [THREAD_NUM-1:0] mask;
        logic [INST_W-1:0]     inst;

        do_reset();
        check_eq("rst_full", ENT_W'(warp_full), '0);
        check_eq("rst_nonempty", ENT_W'(warp_nonempty), '0);
        check_eq("rst_out_valid", ENT_W'(out_valid), '0);
        check_eq("rst_out_data", {out_pc, out_thread_mask, out_inst}, '0);
        check_eq("rst_out_warp", ENT_W'(out_warp_num), '0);
        check_eq("rst_overflow", ENT_W'(overflow_err), '0);

        // Single write then pop, then hold
        write(3'd3, 32'h100, 32'hFFFF_FFFF, 64'hA5);
        check_eq("t1_nonempty", ENT_W'(warp_nonempty), ENT_W'(8'h08));
        pop(3'd3);
        check_out("t1_pop", 3'd3, 32'h100, 32'hFFFF_FFFF, 64'hA5);
        check_eq("t1_nonempty_after", ENT_W'(warp_nonempty), '0);
        pop(3'd3);
        check_eq("t1_empty_pop_valid", ENT_W'(out_valid), '0);
        check_eq("t1_hold_pc", ENT_W'(out_pc), ENT_W'(32'h100));

        // Fill warp 1, overflow, drain in order
        write(3'd1, 32'h10, 32'h0000_000F, 64'h10);
        write(3'd1, 32'h14, 32'h0000_00F0, 64'h14);
        check_eq("t2_full", ENT_W'(warp_full), ENT_W'(8'h02));
        check_eq("t2_no_ovf_yet", ENT_W'(overflow_err), '0);
        write(3'd1, 32'h18, 32'h0000_0F00, 64'h18);
        check_eq("t2_overflow", ENT_W'(overflow_err), ENT_W'(1'b1));
        check_eq("t2_still_full", ENT_W'(warp_full), ENT_W'(8'h02));
        pop(3'd1);
        check_out("t2_pop0", 3'd1, 32'h10, 32'h0000_000F, 64'h10);
        pop(3'd1);
        check_out("t2_pop1", 3'd1, 32'h14, 32'h0000_00F0, 64'h14);
        check_eq("t2_drained", ENT_W'(warp_nonempty), '0);
        do_reset();
        check_eq("t2_ovf_cleared", ENT_W'(overflow_err), '0);

        // Full warp: same-cycle write and pop
        write(3'd2, 32'h20, 32'h2, 64'h20);
        write(3'd2, 32'h24, 32'h4, 64'h24);
        drive(1'b1, 3'd2, 32'h28, 32'h8, 64'h28, 1'b1, 3'd2, 1'b0, '0);
        check_out("t3_pop0", 3'd2, 32'h20, 32'h2, 64'h20);
        check_eq("t3_full", ENT_W'(warp_full), ENT_W'(8'h04));
        check_eq("t3_no_ovf", ENT_W'(overflow_err), '0);
        pop(3'd2);
        check_out("t3_pop1", 3'd2, 32'h24, 32'h4, 64'h24);
        pop(3'd2);
        check_out("t3_pop2", 3'd2, 32'h28, 32'h8, 64'h28);
        check_eq("t3_drained", ENT_W'(warp_nonempty), '0);

        // No bypass: write and pop an empty warp in the same cycle
        drive(1'b1, 3'd5, 32'h50, 32'h5, 64'h50, 1'b1, 3'd5, 1'b0, '0);
        check_eq("byp_valid", ENT_W'(out_valid), '0);
        check_eq("byp_nonempty", ENT_W'(warp_nonempty), ENT_W'(8'h20));
        pop(3'd5);
        check_out("byp_pop", 3'd5, 32'h50, 32'h5, 64'h50);

        // Flush beats pop and write on the same warp
        write(3'd0, 32'h0, 32'h1, 64'h1);
        write(3'd0, 32'h4, 32'h2, 64'h2);
        drive(1'b1, 3'd0, 32'h8, 32'h3, 64'h3, 1'b1, 3'd0, 1'b1, 3'd0);
        check_eq("t4_out_valid", ENT_W'(out_valid), '0);
        check_eq("t4_nonempty", ENT_W'(warp_nonempty), '0);
        check_eq("t4_no_ovf", ENT_W'(overflow_err), '0);

        // Flush of another warp leaves pop and write alone
        write(3'd6, 32'h60, 32'h6, 64'h60);
        write(3'd7, 32'h70, 32'h7, 64'h70);
        drive(1'b1, 3'd4, 32'h40, 32'h4, 64'h40, 1'b1, 3'd6, 1'b1, 3'd7);
        check_out("iso_pop", 3'd6, 32'h60, 32'h6, 64'h60);
        check_eq("iso_nonempty", ENT_W'(warp_nonempty), ENT_W'(8'h10));
        pop(3'd4);
        check_out("iso_pop4", 3'd4, 32'h40, 32'h4, 64'h40);

        // Interleaved traffic over all warps with pointer wrap
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                for (int w = 0; w < WARP_NUM; w++) begin
                    pc   = 32'h1000 + 32'(w * 256 + r * 8 + k * 4);
                    mask = 32'(w * 16 + r * 2 + k) | 32'h8000_0000;
                    inst = 64'hC0DE_0000_0000_0000 | 64'(pc);
                    write(WW'(w), pc, mask, inst);
                    exp_q.push_back({pc, mask, inst});
                end
            end
            check_eq("il_all_full", ENT_W'(warp_full), ENT_W'(8'hFF));
            for (int k = 0; k < DEPTH; k++) begin
                for (int w = 0; w < WARP_NUM; w++) begin
                    pop(WW'(w));
                    check_eq("il_valid", ENT_W'(out_valid), ENT_W'(1'b1));
                    check_eq("il_warp", ENT_W'(out_warp_num), ENT_W'(w));
                    if (exp_q.size() > 0)
                        check_eq("il_data", {out_pc, out_thread_mask, out_inst}, exp_q.pop_front());
                    else
                        check_eq("il_queue_empty", ENT_W'(exp_q.size()), ENT_W'(1));
                end
            end
            check_eq("il_drained", ENT_W'(warp_nonempty), '0);
        end
        check_eq("il_overflow", ENT_W'(overflow_err), '0);

        // Reset while busy; in-flight write during reset is ignored
        for (int w = 0; w < WARP_NUM; w++)
            write(WW'(w), 32'h700 + 32'(w), 32'h1, 64'h7);
        write(3'd1, 32'h800, 32'h1, 64'h8);
        write(3'd1, 32'h804, 32'h1, 64'h8);
        check_eq("t6_ovf_set", ENT_W'(overflow_err), ENT_W'(1'b1));
        pop(3'd2);
        check_out("t6_pop", 3'd2, 32'h702, 32'h1, 64'h7);
        rst = 1'b1;
        in_valid = 1'b1;
        in_warp_num = 3'd3;
        in_pc = 32'h900;
        issue_req = 1'b1;
        issue_warp = 3'd4;
        tick();
        rst = 1'b0;
        clear_inputs();
        check_eq("t6_nonempty", ENT_W'(warp_nonempty), '0);
        check_eq("t6_out_valid", ENT_W'(out_valid), '0);
        check_eq("t6_ovf", ENT_W'(overflow_err), '0);
        check_eq("t6_out_pc", ENT_W'(out_pc), '0);
        tick();
        check_eq("t6_still_empty", ENT_W'(warp_nonempty), '0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gelato_ibuffer.md
Name: gelato_ibuffer

Overview:
- Per-warp instruction buffer directly downstream of instruction decode.
- Captures each decoded instruction (pc, warp number, thread mask, decoded instruction word) into a small FIFO owned by that warp.
- Exposes per-warp occupancy to fetch (stall) and to the warp scheduler (issue eligibility).
- Pops the head of the scheduler-selected warp into a registered issue output.

Parameters:
- WARP_NUM, 8, number of warps; one FIFO per warp.
- DEPTH, 2, entries per warp FIFO; power of two, ≥2.
- ADDR_W, 32, pc width.
- THREAD_NUM, 32, threads per warp; thread mask width.
- INST_W, 64, width of the packed decoded-instruction struct.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  decode presents an instruction this cycle.
- in_pc  in  ADDR_W  instruction pc.
- in_warp_num  in  clog2(WARP_NUM)  owning warp.
- in_thread_mask  in  THREAD_NUM  active threads.
- in_inst  in  INST_W  decoded instruction.
- warp_full  out  WARP_NUM  bit w=1: warp w FIFO full; fetch must not send warp w.
- warp_nonempty  out  WARP_NUM  bit w=1: warp w holds ≥1 entry; scheduler eligibility.
- issue_req  in  1  scheduler pops one entry.
- issue_warp  in  clog2(WARP_NUM)  warp to pop.
- flush_valid  in  1  discard all entries of flush_warp (branch/divergence redirect).
- flush_warp  in  clog2(WARP_NUM)  warp to flush.
- out_valid  out  1  issue outputs hold a popped instruction.
- out_pc  out  ADDR_W  popped pc.
- out_warp_num  out  clog2(WARP_NUM)  popped warp.
- out_thread_mask  out  THREAD_NUM  popped mask.
- out_inst  out  INST_W  popped instruction.
- overflow_err  out  1  sticky: a write targeted a full warp.

Behaviour:
- Storage: per warp, DEPTH-entry circular FIFO with rd_ptr, wr_ptr (clog2(DEPTH) bits, wrap modulo DEPTH) and count (clog2(DEPTH+1) bits, range 0..DEPTH).
- Reset (rst=1 at edge): all pointers/counts 0, out_valid 0, out_pc/out_warp_num/out_thread_mask/out_inst 0, overflow_err 0. Entry contents are don't-care. Reset mid-operation discards everything; in-flight inputs that cycle are ignored.
- Status outputs are combinational from registered state: warp_full[w] = (count[w]==DEPTH); warp_nonempty[w] = (count[w]!=0).
- Write: in_valid=1 and warp not full → store at wr_ptr, wr_ptr+1, count+1. Write to a full warp → dropped, overflow_err set (stays set until rst).
- Pop: issue_req=1 and warp_nonempty[issue_warp] → head copied to out_* at the edge; out_valid=1 next cycle; rd_ptr+1, count-1. Latency is 1 cycle from issue_req to out_valid.
- issue_req to an empty warp → no pop; out_valid=0 next cycle. No write-to-read bypass: an entry written in cycle N is poppable from cycle N+1.
- out_valid deasserts the cycle after any cycle without a successful pop. Outputs hold their last values when out_valid=0.
- Same-warp write and pop in one cycle (warp nonempty): both occur, count unchanged. If the warp is full, the pop frees a slot and the write is accepted; overflow_err not set.
- Flush: flush_valid=1 → rd_ptr=wr_ptr=count=0 for flush_warp at the edge.
- Flush and write to the same warp: flush wins; write dropped silently (no overflow_err).
- Flush and pop to the same warp: flush wins; no pop; out_valid=0 next cycle.
- Flush of warp A does not affect writes or pops to warp B≠A in the same cycle.
- No combinational path from in_* to out_*.

Test Plan:
- Reset, then write warp 3 (pc=0x100, mask=0xFFFFFFFF, inst=0xA5); next cycle issue_req warp 3 → cycle after: out_valid=1, out_pc=0x100, out_warp_num=3, out_inst=0xA5; warp_nonempty[3]=0.
- Two writes to warp 1 (pc 0x10, 0x14) with DEPTH=2 → warp_full[1]=1; third write pc 0x18 → dropped, overflow_err=1; two pops return 0x10 then 0x14 in order.
- Warp 2 full; same-cycle write pc 0x28 and pop → pop returns oldest, count stays 2, overflow_err=0; later pops yield the remaining entries in FIFO order ending with 0x28.
- Warp 0 holds 2 entries; flush warp 0 in the same cycle as pop warp 0 and write warp 0 → next cycle out_valid=0, warp_nonempty[0]=0, overflow_err=0.
- Interleaved writes to warps 0..7 with pointer wrap (≥5 write/pop rounds per warp) → per-warp FIFO order preserved, out_warp_num matches issue_warp.
- Assert rst while warps hold entries and out_valid=1 → next cycle all warp_nonempty=0, out_valid=0, overflow_err=0.
